// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, WIDTH cycles per add.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    count_q, count_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic accept;
   logic last_bit;
   logic bit_s;
   logic bit_c;

   // start is only honoured outside RUN, so a mid-operation request is dropped.
   assign accept   = start && (state_q != ST_RUN);
   assign last_bit = (state_q == ST_RUN) && (count_q == CW'(WIDTH - 1));

   assign bit_s = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
   assign bit_c = (shift_a_q[0] & shift_b_q[0]) |
                  (shift_a_q[0] & carry_q) |
                  (shift_b_q[0] & carry_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   always_comb begin
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      count_d   = count_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      if (accept) begin
         shift_a_d = a;
         shift_b_d = b;
         carry_d   = cin;
         count_d   = '0;
      end else if (state_q == ST_RUN) begin
         shift_a_d = shift_a_q >> 1;
         shift_b_d = shift_b_q >> 1;
         acc_d     = {bit_s, acc_q[WIDTH-1:1]};
         carry_d   = bit_c;
         count_d   = count_q + CW'(1);
         if (last_bit) begin
            sum_d  = {bit_s, acc_q[WIDTH-1:1]};
            cout_d = bit_c;
            // carry_q is the carry into the MSB slice on the final bit.
            ovf_d  = carry_q ^ bit_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a_q <= '0;
         shift_b_q <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         count_q   <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule
